// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a shift counter that pulses frame_done after every WIDTH shifts.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en         clock enable, all state holds when low
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin        serial data input
//   din        parallel load data
//   q          registered register contents
//   sout       serial output bit, combinational from q, mode and dir_last
//   cnt        shifts since last load, frame wrap or reset
//   frame_done one-cycle pulse after the WIDTH-th shift of a frame
module shift_reg_universal #(
   parameter int             WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int             CNT_W     = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic [CNT_W-1:0] cnt,
   output logic             frame_done
);

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_RIGHT = 2'b01;
   localparam logic [1:0] M_LEFT  = 2'b10;
   localparam logic [1:0] M_LOAD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // 0 = last shift was right, 1 = last shift was left
   logic             dir_last;

   logic [WIDTH-1:0] q_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fd_nxt;
   logic             dir_nxt;
   logic             shift;
   logic             wrap;

   assign wrap = (cnt == CNT_LAST);

   always_comb begin
      q_nxt   = q;
      cnt_nxt = cnt;
      fd_nxt  = 1'b0;
      dir_nxt = dir_last;
      shift   = 1'b0;
      if (en) begin
         unique case (mode)
            M_HOLD: begin
               q_nxt = q;
            end
            M_RIGHT: begin
               q_nxt   = {sin, q[WIDTH-1:1]};
               dir_nxt = 1'b0;
               shift   = 1'b1;
            end
            M_LEFT: begin
               q_nxt   = {q[WIDTH-2:0], sin};
               dir_nxt = 1'b1;
               shift   = 1'b1;
            end
            M_LOAD: begin
               q_nxt   = din;
               cnt_nxt = '0;
            end
         endcase
      end
      // Direction changes do not restart the frame; cnt counts
      // every shift regardless of direction.
      if (shift) begin
         cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
         fd_nxt  = wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q          <= RESET_VAL;
         cnt        <= '0;
         frame_done <= 1'b0;
         dir_last   <= 1'b0;
      end else begin
         q          <= q_nxt;
         cnt        <= cnt_nxt;
         frame_done <= fd_nxt;
         dir_last   <= dir_nxt;
      end
   end

   // The bit about to leave follows the active shift direction; when
   // idle or loading, it follows the direction of the last shift.
   always_comb begin
      sout = q[0];
      unique case (mode)
         M_RIGHT: sout = q[0];
         M_LEFT:  sout = q[WIDTH-1];
         default: sout = dir_last ? q[WIDTH-1] : q[0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!$isunknown(en));
         if (en) begin
            assert (!$isunknown(mode));
         end
      end
   end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=4): directed
// scenarios followed by randomized steps against an arithmetic model.
module tb_shift_reg_universal;

   localparam int W  = 4;
   localparam int CW = $clog2(W) + 1;
   localparam int MSB_W = 2 ** (W - 1);
   localparam int MOD_W = 2 ** W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [1:0]    mode;
   logic          sin;
   logic [W-1:0]  din;
   logic [W-1:0]  q;
   logic          sout;
   logic [CW-1:0] cnt;
   logic          frame_done;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference model state: value, shifts in current frame,
   // expected pulse, last direction (0 right, 1 left).
   int m_q;
   int m_sh;
   int m_fd;
   int m_dir;
   bit m_valid = 1'b0;

   shift_reg_universal #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .sin        (sin),
      .din        (din),
      .q          (q),
      .sout       (sout),
      .cnt        (cnt),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_sout(input int md);
      int lsb;
      int msb;
      lsb = m_q % 2;
      msb = m_q / MSB_W;
      if (md == 1) return lsb;
      if (md == 2) return msb;
      return (m_dir == 1) ? msb : lsb;
   endfunction

   // One clock: drive, check sout before the edge, clock, update the
   // model, then check the registered outputs.
   task automatic step(input bit r, input bit e, input int md,
                       input bit s, input int d);
      rst_n = r;
      en    = e;
      mode  = 2'(md);
      sin   = s;
      din   = W'(d);
      #1;
      if (m_valid) chk("sout", 32'(sout), 32'(exp_sout(md)));
      @(posedge clk);
      #1;
      if (!r) begin
         m_q = 0; m_sh = 0; m_fd = 0; m_dir = 0; m_valid = 1'b1;
      end else if (!e || md == 0) begin
         m_fd = 0;
      end else if (md == 3) begin
         m_q = d % MOD_W; m_sh = 0; m_fd = 0;
      end else begin
         if (md == 1) begin
            m_q = m_q / 2 + (s ? MSB_W : 0);
            m_dir = 0;
         end else begin
            m_q = (m_q * 2 + int'(s)) % MOD_W;
            m_dir = 1;
         end
         m_sh++;
         m_fd = (m_sh == W) ? 1 : 0;
         if (m_fd == 1) m_sh = 0;
      end
      if (m_valid) begin
         chk("q", 32'(q), 32'(m_q));
         chk("cnt", 32'(cnt), 32'(m_sh));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
      end
   endtask

   initial begin
      int p2q[4];
      int p2c[4];
      int p3s[4];
      int pulses;
      p2q = '{8, 4, 10, 13};
      p2c = '{1, 2, 3, 0};
      p3s = '{1, 0, 0, 1};

      // Reset dominates an active shift request
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_fd", 32'(frame_done), 0);
      step(1, 1, 1, 1, 0);
      chk("rst_first_shift", 32'(q), 32'h8);

      // SISO right: 1,0,1,1
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, (i != 1), 0);
         chk("siso_q", 32'(q), 32'(p2q[i]));
         chk("siso_cnt", 32'(cnt), 32'(p2c[i]));
         chk("siso_fd", 32'(frame_done), (i == 3) ? 1 : 0);
      end
      chk("siso_sout", 32'(sout), 1);

      // PISO left from a parallel load
      step(1, 1, 3, 0, 4'b1001);
      chk("piso_load_cnt", 32'(cnt), 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         mode = 2'b10;
         sin  = 1'b0;
         #1;
         chk("piso_sout", 32'(sout), 32'(p3s[i]));
         step(1, 1, 2, 0, 0);
         pulses += int'(frame_done);
      end
      chk("piso_final_q", 32'(q), 0);
      chk("piso_pulses", 32'(pulses), 1);

      // Enable gating mid-frame
      step(1, 1, 3, 0, 0);
      step(1, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 1, 5);
         chk("gate_hold_q", 32'(q), 32'hC);
         chk("gate_hold_fd", 32'(frame_done), 0);
      end
      step(1, 1, 1, 0, 0);
      chk("gate_3rd_fd", 32'(frame_done), 0);
      step(1, 1, 1, 0, 0);
      chk("gate_final_q", 32'(q), 32'h3);
      chk("gate_final_fd", 32'(frame_done), 1);

      // Load mid-frame restarts the frame
      step(1, 1, 3, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
      chk("ldmid_cnt3", 32'(cnt), 3);
      step(1, 1, 3, 0, 4'b0110);
      chk("ldmid_q", 32'(q), 32'h6);
      chk("ldmid_cnt0", 32'(cnt), 0);
      chk("ldmid_fd", 32'(frame_done), 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 2, 0, 0);
         chk("ldmid_early_fd", 32'(frame_done), 0);
      end
      step(1, 1, 2, 0, 0);
      chk("ldmid_fd4", 32'(frame_done), 1);

      // Direction change keeps counting; reset beats a load
      step(1, 1, 3, 0, 0);
      step(1, 1, 1, 1, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 2, 1, 0);
      chk("dir_cnt3", 32'(cnt), 3);
      step(1, 1, 1, 0, 0);
      chk("dir_fd", 32'(frame_done), 1);
      chk("dir_cnt0", 32'(cnt), 0);
      step(1, 1, 2, 1, 0);
      step(0, 1, 3, 0, 4'hF);
      chk("rstload_q", 32'(q), 0);
      chk("rstload_cnt", 32'(cnt), 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 24) != 0),
              ($urandom_range(0, 7) != 0),
              int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, MOD_W - 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
